// File: rtl/rst_seq_pkg.sv
// Shared types and width helpers for the reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } rst_state_t;

    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for slow asynchronous level inputs.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Holds all reset domains until PLL lock is stable, then releases them
// in index order with a fixed gap; restarts on lock loss or sw request.
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_STAGES  = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 8
) (
    input  logic                  i_aclk,
    input  logic                  i_reset,
    input  logic                  i_locked,
    input  logic                  i_sw_reset_req,
    output logic                  o_sw_reset_ack,
    output logic [NUM_STAGES-1:0] o_stage_reset_n,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES, STAGE_GAP);
    localparam int IDX_W = idx_width(NUM_STAGES);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STAGES - 1);

    logic lk;

    rst_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  pend_q, pend_d;
    logic [NUM_STAGES-1:0] stage_q, stage_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ack_q, ack_d;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk (i_aclk),
        .rst (i_reset),
        .d   (i_locked),
        .q   (lk)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        stage_d = stage_q;
        ack_d   = 1'b0;
        unique case (state_q)
            HOLD: begin
                stage_d = '0;
                idx_d   = '0;
                if (!lk) begin
                    cnt_d = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d    = RELEASE;
                    cnt_d      = '0;
                    stage_d[0] = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                if (!lk) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    stage_d = '0;
                end else if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = RUN;
                        if (pend_q) begin
                            pend_d = 1'b0;
                            ack_d  = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                        for (int k = 0; k < NUM_STAGES; k++) begin
                            if (IDX_W'(k) == idx_d) stage_d[k] = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                // A request seen during the ack cycle belongs to the finished sequence.
                if (!lk || (i_sw_reset_req && !ack_q)) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    stage_d = '0;
                    if (i_sw_reset_req && !ack_q) pend_d = 1'b1;
                end
            end
            default: begin
                state_d = HOLD;
                cnt_d   = '0;
                stage_d = '0;
            end
        endcase
        busy_d = (state_d != RUN);
        done_d = (state_d == RUN);
    end

    always_ff @(posedge i_aclk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            pend_q  <= 1'b0;
            stage_q <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            stage_q <= stage_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
        end
    end

    assign o_stage_reset_n = stage_q;
    assign o_busy          = busy_q;
    assign o_done          = done_q;
    assign o_sw_reset_ack  = ack_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: stimulus queues expected output changes, monitor checks them.
module tb_reset_sequencer;

    logic       clk;
    logic       i_reset;
    logic       i_locked;
    logic       i_sw_reset_req;
    logic       o_sw_reset_ack;
    logic [3:0] o_stage_reset_n;
    logic       o_busy;
    logic       o_done;

    int cyc;
    int errors;
    int checks;

    typedef struct {
        int         cyc;
        logic [6:0] val;
    } ev_t;

    ev_t exp_q[$];

    localparam logic [6:0] RST_VAL = 7'b0010000;

    reset_sequencer #(
        .NUM_STAGES  (4),
        .HOLD_CYCLES (16),
        .STAGE_GAP   (8)
    ) dut (
        .i_aclk          (clk),
        .i_reset         (i_reset),
        .i_locked        (i_locked),
        .i_sw_reset_req  (i_sw_reset_req),
        .o_sw_reset_ack  (o_sw_reset_ack),
        .o_stage_reset_n (o_stage_reset_n),
        .o_busy          (o_busy),
        .o_done          (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic [6:0] v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        exp_q.push_back(e);
    endtask

    // Output order {ack, done, busy, stage[3:0]}; l = first cycle lk is 1.
    task automatic push_seq(input int l, input logic pend);
        push(l + 16, 7'b0010001);
        push(l + 24, 7'b0010011);
        push(l + 32, 7'b0010111);
        push(l + 40, 7'b0011111);
        push(l + 48, {pend, 6'b101111});
        if (pend) push(l + 49, 7'b0101111);
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_empty(input string name, input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: %0d events pending, required 0",
                     name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic chk_now(input string name, input logic [6:0] exp);
        logic [6:0] got;
        got = {o_sw_reset_ack, o_done, o_busy, o_stage_reset_n};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b required=%b", name, got, exp);
        end
    endtask

    // Monitor: every output change must match the next queued event.
    initial begin
        logic [6:0] prev;
        logic [6:0] cur;
        ev_t        e;
        prev = RST_VAL;
        forever begin
            @(negedge clk);
            cur = {o_sw_reset_ack, o_done, o_busy, o_stage_reset_n};
            if (cur !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change cyc=%0d got=%b",
                             cyc, cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e.val || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL event cyc=%0d got=%b required cyc=%0d val=%b",
                                 cyc, cur, e.cyc, e.val);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        int n;
        int l;
        errors         = 0;
        checks         = 0;
        i_reset        = 1'b1;
        i_locked       = 1'b1;
        i_sw_reset_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_now("reset_state", RST_VAL);

        // Power-on sequence
        n = cyc;
        i_reset = 1'b0;
        push_seq(n + 2, 1'b0);
        wait_empty("power_on", 100);

        // Lock loss in RUN, then a one-cycle glitch at hold count 10
        n = cyc;
        i_locked = 1'b0;
        push(n + 3, RST_VAL);
        wait_to(n + 5);
        i_locked = 1'b1;
        l = n + 7;
        wait_to(l + 8);
        i_locked = 1'b0;
        wait_to(l + 9);
        i_locked = 1'b1;
        push_seq(l + 11, 1'b0);
        wait_empty("lock_loss_glitch", 120);

        // SW request held one cycle past ack restarts a second time
        n = cyc;
        i_sw_reset_req = 1'b1;
        push(n + 1, RST_VAL);
        l = n + 1;
        push_seq(l, 1'b1);
        wait_to(l + 49);
        push(l + 50, RST_VAL);
        push_seq(l + 50, 1'b1);
        wait_to(l + 50);
        i_sw_reset_req = 1'b0;
        wait_empty("sw_request", 120);

        // Request and lock loss seen on the same RUN edge
        n = cyc;
        i_locked = 1'b0;
        wait_to(n + 2);
        i_sw_reset_req = 1'b1;
        push(n + 3, RST_VAL);
        wait_to(n + 3);
        i_sw_reset_req = 1'b0;
        wait_to(n + 5);
        i_locked = 1'b1;
        push_seq(n + 7, 1'b1);
        wait_empty("req_and_lock_loss", 120);

        // Async reset mid-RELEASE clears pend: no ack afterwards
        n = cyc;
        i_sw_reset_req = 1'b1;
        push(n + 1, RST_VAL);
        l = n + 1;
        wait_to(n + 1);
        i_sw_reset_req = 1'b0;
        push(l + 16, 7'b0010001);
        push(l + 24, 7'b0010011);
        push(l + 26, RST_VAL);
        wait_to(l + 26);
        chk_now("bits_before_reset", 7'b0010011);
        i_reset = 1'b1;
        #1;
        chk_now("async_reset", RST_VAL);
        wait_to(l + 28);
        i_reset = 1'b0;
        push_seq(l + 30, 1'b0);
        wait_empty("after_reset", 120);

        repeat (20) @(posedge clk);
        #1;
        chk_now("final_run", 7'b0101111);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
